// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: issues word reads, buffers responses in an
// in-order prefetch FIFO and presents the head to the IF/ID register.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [AW-1:0] PONE    = AW'(1);
  localparam logic [31:0]   NOP     = 32'h0000_0001;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   last_addr;
  logic [31:0]   jump_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW-1:0] out_nx;
  logic [CW:0]   inflight;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [31:0]   mem_addr [FIFO_DEPTH];
  logic          held;
  logic          empty;
  logic          full;
  logic          grant;
  logic          rv_ok;
  logic          drop;
  logic          push;
  logic          pop;
  logic          unused_ok;

  assign unused_ok = ^jump_addr_i[1:0];
  assign jump_pc   = {jump_addr_i[31:2], 2'b00};

  assign held     = |hold_flag_i;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign inflight = {1'b0, count} + {1'b0, outstanding};

  // Slots are reserved at request time, so the FIFO cannot overflow
  assign ibus_req_o  = !rst && !held && (inflight < {1'b0, DEPTH_C});
  assign ibus_addr_o = fetch_pc;

  assign grant = ibus_req_o && ibus_gnt_i;
  assign rv_ok = ibus_rvalid_i && (outstanding != '0);
  assign drop  = rv_ok && (discard != '0);
  assign push  = rv_ok && (discard == '0) && !full && !jump_flag_i;
  assign pop   = !empty && !held && !jump_flag_i;

  assign inst_valid_o = !empty;
  assign inst_o       = empty ? NOP : mem_data[rd_ptr];
  assign inst_addr_o  = empty ? last_addr : mem_addr[rd_ptr];

  always_comb begin
    out_nx = outstanding;
    if (grant && !rv_ok) begin
      out_nx = outstanding + ONE;
    end else if (!grant && rv_ok) begin
      out_nx = outstanding - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      last_addr   <= '0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= out_nx;
      if (jump_flag_i) begin
        // every read still in flight belongs to the old stream
        fetch_pc <= jump_pc;
        resp_pc  <= jump_pc;
        discard  <= out_nx;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (drop) begin
          discard <= discard - ONE;
        end
        if (push) begin
          wr_ptr  <= wr_ptr + PONE;
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr    <= rd_ptr + PONE;
          last_addr <= mem_addr[rd_ptr];
        end
        if (push && !pop) begin
          count <= count + ONE;
        end else if (pop && !push) begin
          count <= count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= ibus_rdata_i;
      mem_addr[wr_ptr] <= resp_pc;
    end
  end

endmodule
